axi_read_splitter: RTL and testbench

Converts one long accelerator read request (32-bit beat count) into a sequence of legal AXI4 AR bursts and forwards the returned R beats back to the requester. It sits directly downstream of the accelerator read-request/read-data port (`xcel_read_*`) and upstream of the memory read port (`mem_model` or the AXI interconnect). Each sub-burst obeys two limits: the AXI 256-beat INCR cap (16-beat FIXED cap) and the 4 KB boundary rule.

---
 rtl/axi_pkg.sv | 19 +
 rtl/burst_chunk_calc.sv | 32 +++
 rtl/axi_read_splitter.sv | 161 ++++++++++++++++
 tb/tb_axi_read_splitter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and the read splitter state encoding.
// Imported by the splitter top and its chunk calculator.
package axi_pkg;

   localparam logic [1:0] AXI_FIXED = 2'b00;
   localparam logic [1:0] AXI_INCR  = 2'b01;
   localparam logic [1:0] AXI_WRAP  = 2'b10;

   localparam int unsigned AXI_4KB       = 4096;
   localparam int unsigned AXI_MAX_INCR  = 256;
   localparam int unsigned AXI_MAX_FIXED = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DATA
   } state_t;

endpackage

// File: rtl/burst_chunk_calc.sv
// Sub-burst sizing: min(remaining, burst cap, 4 KB boundary).
// Produces the AXI length field (chunk - 1).
module burst_chunk_calc
   import axi_pkg::*;
(
   input  logic [11:0] offs,
   input  logic [31:0] remaining,
   input  logic [2:0]  size,
   input  logic [1:0]  burst,
   output logic [7:0]  len
);

   logic [31:0] cap;
   logic [31:0] bnd;
   logic [31:0] chunk;

   // Clamp the beat count by cap and page boundary
   always_comb begin
      cap = (burst == AXI_INCR) ? AXI_MAX_INCR : AXI_MAX_FIXED;
      bnd = 32'hFFFF_FFFF;
      if (burst == AXI_INCR) begin
         bnd = (AXI_4KB - {20'd0, offs}) >> size;
         // Misaligned start near the page end: still move one beat
         if (bnd == 32'd0) bnd = 32'd1;
      end
      chunk = remaining;
      if (cap < chunk) chunk = cap;
      if (bnd < chunk) chunk = bnd;
      len = 8'(chunk - 32'd1);
   end

endmodule

// File: rtl/axi_read_splitter.sv
// Splits one long read request into legal AXI4 AR bursts
// and forwards returned R beats straight to the requester.
module axi_read_splitter
   import axi_pkg::*;
#(
   parameter int AXI_AWIDTH = 32,
   parameter int AXI_DWIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [AXI_AWIDTH-1:0] req_addr,
   input  logic [31:0]           req_len,
   input  logic [2:0]            req_size,
   input  logic [1:0]            req_burst,
   output logic                  ar_valid,
   input  logic                  ar_ready,
   output logic [AXI_AWIDTH-1:0] ar_addr,
   output logic [7:0]            ar_len,
   output logic [2:0]            ar_size,
   output logic [1:0]            ar_burst,
   input  logic [AXI_DWIDTH-1:0] r_data,
   input  logic                  r_valid,
   input  logic                  r_last,
   output logic                  r_ready,
   output logic [AXI_DWIDTH-1:0] data,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  busy,
   output logic                  err
);

   localparam logic [2:0] MAX_SIZE = 3'($clog2(AXI_DWIDTH / 8));

   state_t                  state;
   state_t                  state_nxt;
   logic [AXI_AWIDTH-1:0]   addr_q;
   logic [31:0]             rem_q;
   logic [7:0]              cnt_q;
   logic [11:0]             c_offs;
   logic [31:0]             c_rem;
   logic [2:0]              c_size;
   logic [1:0]              c_burst;
   logic [7:0]              c_len;
   logic [8:0]              chunk;
   logic                    illegal;
   logic                    beat;

   assign illegal = req_burst[1] | (req_size > MAX_SIZE);
   assign beat    = (state == ST_DATA) & r_valid & data_ready;
   assign chunk   = {1'b0, ar_len} + 9'd1;
   assign data    = r_data;
   assign busy    = (state != ST_IDLE);

   // Chunk inputs: the new request in IDLE, latched progress later
   always_comb begin
      if (state == ST_IDLE) begin
         c_offs  = req_addr[11:0];
         c_rem   = req_len + 32'd1;
         c_size  = req_size;
         c_burst = req_burst;
      end else begin
         c_offs  = addr_q[11:0];
         c_rem   = rem_q;
         c_size  = ar_size;
         c_burst = ar_burst;
      end
   end

   burst_chunk_calc u_calc (
      .offs      (c_offs),
      .remaining (c_rem),
      .size      (c_size),
      .burst     (c_burst),
      .len       (c_len)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state and handshake outputs
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      ar_valid   = 1'b0;
      r_ready    = 1'b0;
      data_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = ~rst;
            if (req_valid && !illegal) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            ar_valid = 1'b1;
            if (ar_ready) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            r_ready    = data_ready;
            data_valid = r_valid;
            if (beat && r_last)
               state_nxt = (rem_q != 32'd0) ? ST_ISSUE : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request latch, burst progress, beat counter and error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         err      <= 1'b0;
         ar_addr  <= '0;
         ar_len   <= '0;
         ar_size  <= '0;
         ar_burst <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  err <= illegal;
                  if (!illegal) begin
                     addr_q   <= req_addr;
                     rem_q    <= c_rem;
                     ar_addr  <= req_addr;
                     ar_len   <= c_len;
                     ar_size  <= req_size;
                     ar_burst <= req_burst;
                  end
               end
            end
            ST_ISSUE: begin
               if (ar_ready) begin
                  rem_q <= rem_q - 32'(chunk);
                  if (ar_burst == AXI_INCR)
                     addr_q <= addr_q + (AXI_AWIDTH'(chunk) << ar_size);
                  cnt_q <= ar_len;
               end
            end
            ST_DATA: begin
               if (beat) begin
                  cnt_q <= cnt_q - 8'd1;
                  if (r_last != (cnt_q == 8'd0)) err <= 1'b1;
                  if (r_last) begin
                     ar_addr <= addr_q;
                     ar_len  <= c_len;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_read_splitter.sv
// Scoreboard bench for axi_read_splitter.
// Expected ARs and data beats are queued as requests are driven.
module tb_axi_read_splitter;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  l;
   } ar_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_len;
   logic [2:0]  req_size;
   logic [1:0]  req_burst;
   logic        ar_valid;
   logic        ar_ready;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic [31:0] r_data;
   logic        r_valid;
   logic        r_last;
   logic        r_ready;
   logic [31:0] data;
   logic        data_valid;
   logic        data_ready;
   logic        busy;
   logic        err;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] src = 32'h1000_0000;
   ar_t         ar_q[$];
   logic [31:0] d_q[$];

   axi_read_splitter dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .req_size   (req_size),
      .req_burst  (req_burst),
      .ar_valid   (ar_valid),
      .ar_ready   (ar_ready),
      .ar_addr    (ar_addr),
      .ar_len     (ar_len),
      .ar_size    (ar_size),
      .ar_burst   (ar_burst),
      .r_data     (r_data),
      .r_valid    (r_valid),
      .r_last     (r_last),
      .r_ready    (r_ready),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
      ar_t e;
      e.a = a;
      e.l = l;
      ar_q.push_back(e);
   endtask

   task automatic do_req(input logic [31:0] a, input logic [31:0] l,
                         input logic [2:0] s, input logic [1:0] b,
                         input int stall, input bit rnd,
                         input int last_at, input bit exp_err);
      ar_t e;
      int  total, beats, stop, bi, budget;
      bit  xfer;
      total = (last_at != 0) ? last_at : int'(l) + 1;
      for (int i = 0; i < total; i++) d_q.push_back(src + 32'(i));
      req_valid = 1'b1;
      req_addr  = a;
      req_len   = l;
      req_size  = s;
      req_burst = b;
      #1;
      chk("req_ready_idle", req_ready, 1);
      tick();
      req_valid = 1'b0;
      while (ar_q.size() > 0) begin
         chk("ar_lat", ar_valid, 1);
         budget = 0;
         while (!ar_valid && budget < 20) begin
            tick();
            budget++;
         end
         e = ar_q.pop_front();
         chk("ar_addr", ar_addr, e.a);
         chk("ar_len", ar_len, e.l);
         chk("ar_size", ar_size, s);
         chk("ar_burst", ar_burst, b);
         r_valid = 1'b1;
         r_last  = 1'b0;
         data_ready = 1'b1;
         for (int k = 0; k < stall; k++) begin
            chk("no_dv_issue", data_valid, 0);
            chk("no_rr_issue", r_ready, 0);
            tick();
            chk("stall_valid", ar_valid, 1);
            chk("stall_addr", ar_addr, e.a);
            chk("stall_len", ar_len, e.l);
         end
         r_valid  = 1'b0;
         ar_ready = 1'b1;
         tick();
         ar_ready = 1'b0;
         beats = int'(e.l) + 1;
         stop  = (last_at != 0 && last_at < beats) ? last_at : beats;
         bi = 0;
         budget = 0;
         while (bi < stop && budget < 50 * stop) begin
            r_valid    = ($urandom_range(0, 3) != 0);
            data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            r_data     = src;
            r_last     = (bi == stop - 1);
            #1;
            chk("dv_pass", data_valid, r_valid);
            chk("rr_pass", r_ready, data_ready);
            xfer = r_valid && data_ready;
            if (xfer) begin
               if (d_q.size() > 0) chk("data", data, d_q.pop_front());
               else chk("data_extra", 1, 0);
            end
            @(posedge clk);
            #1;
            if (xfer) begin
               bi++;
               src++;
            end
            budget++;
         end
         r_valid    = 1'b0;
         r_last     = 1'b0;
         data_ready = 1'b0;
         if (bi < stop) chk("beat_timeout", bi, stop);
      end
      chk("done_ready", req_ready, 1);
      chk("done_busy", busy, 0);
      chk("done_err", err, exp_err);
      chk("dq_empty", d_q.size(), 0);
      d_q.delete();
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_len    = '0;
      req_size   = '0;
      req_burst  = '0;
      ar_ready   = 1'b0;
      r_data     = '0;
      r_valid    = 1'b0;
      r_last     = 1'b0;
      data_ready = 1'b0;
      tick();
      tick();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_ar_valid", ar_valid, 0);
      chk("rst_ar_addr", ar_addr, 0);
      chk("rst_ar_len", ar_len, 0);
      chk("rst_ar_size", ar_size, 0);
      chk("rst_ar_burst", ar_burst, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_dv", data_valid, 0);
      chk("rst_rr", r_ready, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", req_ready, 1);

      push_ar(32'h000, 8'd99);
      do_req(32'h000, 32'd99, 3'd2, 2'b01, 0, 0, 0, 0);

      push_ar(32'h000, 8'd255);
      push_ar(32'h400, 8'd255);
      push_ar(32'h800, 8'd87);
      do_req(32'h000, 32'd599, 3'd2, 2'b01, 0, 0, 0, 0);

      push_ar(32'hFF0, 8'd3);
      push_ar(32'h1000, 8'd3);
      do_req(32'hFF0, 32'd7, 3'd2, 2'b01, 0, 0, 0, 0);

      push_ar(32'h040, 8'd15);
      push_ar(32'h040, 8'd15);
      push_ar(32'h040, 8'd7);
      do_req(32'h040, 32'd39, 3'd2, 2'b00, 0, 0, 0, 0);

      push_ar(32'h100, 8'd19);
      do_req(32'h100, 32'd19, 3'd2, 2'b01, 5, 1, 0, 0);

      push_ar(32'h200, 8'd3);
      do_req(32'h200, 32'd3, 3'd2, 2'b01, 0, 0, 3, 1);

      req_valid = 1'b1;
      req_addr  = 32'h500;
      req_len   = 32'd3;
      req_size  = 3'd2;
      req_burst = 2'b10;
      tick();
      req_valid = 1'b0;
      chk("ill_burst_err", err, 1);
      chk("ill_burst_ar", ar_valid, 0);
      chk("ill_burst_ready", req_ready, 1);
      chk("ill_burst_busy", busy, 0);
      tick();
      chk("ill_burst_ar2", ar_valid, 0);

      req_valid = 1'b1;
      req_burst = 2'b01;
      req_size  = 3'd3;
      tick();
      req_valid = 1'b0;
      chk("ill_size_err", err, 1);
      chk("ill_size_ar", ar_valid, 0);

      req_valid = 1'b1;
      req_addr  = 32'h300;
      req_len   = 32'd15;
      req_size  = 3'd2;
      req_burst = 2'b01;
      tick();
      req_valid = 1'b0;
      chk("mid_err_clr", err, 0);
      chk("mid_ar_valid", ar_valid, 1);
      ar_ready = 1'b1;
      tick();
      ar_ready   = 1'b0;
      r_valid    = 1'b1;
      data_ready = 1'b1;
      r_data     = 32'hDEAD_0000;
      #1;
      chk("mid_dv", data_valid, 1);
      chk("mid_data", data, 32'hDEAD_0000);
      tick();
      rst = 1'b1;
      #1;
      chk("abort_ar_valid", ar_valid, 0);
      chk("abort_dv", data_valid, 0);
      chk("abort_rr", r_ready, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", req_ready, 0);
      r_valid    = 1'b0;
      data_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("re_ready", req_ready, 1);
      chk("re_err", err, 0);

      push_ar(32'h300, 8'd7);
      do_req(32'h300, 32'd7, 3'd2, 2'b01, 2, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
